// File: rtl/display_scan_ctrl_if.sv
// Entry, load and display signals of the multiplexed 7-segment scan controller.
// The master drives the strobes and reads the display; the slave is the controller.
interface display_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    localparam int CW = $clog2(N_DIGITS + 1);

    logic [3:0]            DIGIT_IN;
    logic                  DIGIT_VALID;
    logic                  LOAD;
    logic [4*N_DIGITS-1:0] LOAD_VALUE;
    logic                  CLEAR;
    logic                  BLANK_LZ;
    logic [6:0]            SEG;
    logic [N_DIGITS-1:0]   DIG_SEL;
    logic [CW-1:0]         DIGIT_COUNT;
    logic                  FULL;

    modport master (
        output DIGIT_IN, DIGIT_VALID, LOAD, LOAD_VALUE, CLEAR, BLANK_LZ,
        input  SEG, DIG_SEL, DIGIT_COUNT, FULL
    );

    modport slave (
        input  DIGIT_IN, DIGIT_VALID, LOAD, LOAD_VALUE, CLEAR, BLANK_LZ,
        output SEG, DIG_SEL, DIGIT_COUNT, FULL
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a calculator-style digit entry buffer.
// Scan timing runs independently of buffer writes; SEG/DIG_SEL lag the scan index by one cycle.
module display_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000
) (
    input logic                CLK,
    input logic                RESET,
    display_scan_ctrl_if.slave bus
);
    localparam int PW = $clog2(PRESCALE);
    localparam int SW = $clog2(N_DIGITS);
    localparam int CW = $clog2(N_DIGITS + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] IDX_LAST = SW'(N_DIGITS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N_DIGITS);

    logic [PW-1:0]         pre_q;
    logic [SW-1:0]         idx_q;
    logic [4*N_DIGITS-1:0] buf_q, buf_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   sel_q, sel_d;
    logic                  tick;
    logic                  full;

    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign tick = (pre_q == PRE_LAST);
    assign full = (cnt_q == CNT_FULL);

    // Strobe priority: CLEAR over LOAD over DIGIT_VALID.
    always_comb begin : buffer_next
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (bus.CLEAR) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (bus.LOAD) begin
            buf_d = bus.LOAD_VALUE;
            cnt_d = CNT_FULL;
        end else if (bus.DIGIT_VALID && !full) begin
            buf_d = {buf_q[4*N_DIGITS-5:0], bus.DIGIT_IN};
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin : display_next
        logic                any_hi;
        logic [N_DIGITS-1:0] blank;
        any_hi = 1'b0;
        blank  = '0;
        // Walk down from the top digit; a digit blanks while everything at or above it is zero.
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            any_hi   = any_hi | (buf_q[4*i +: 4] != 4'h0);
            blank[i] = bus.BLANK_LZ & ~any_hi;
        end
        sel_d        = '0;
        sel_d[idx_q] = 1'b1;
        seg_d        = blank[idx_q] ? 7'h00 : seg_encode(buf_q[4*idx_q +: 4]);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre_q <= '0;
            idx_q <= '0;
            // NOTE: the digit buffer is a handful of flops, not a RAM, so it is reset with everything else.
            buf_q <= '0;
            cnt_q <= '0;
            seg_q <= '0;
            sel_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pre_q <= tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + SW'(1);
            end
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            seg_q <= seg_d;
            sel_q <= sel_d;
        end
    end

    assign bus.SEG         = seg_q;
    assign bus.DIG_SEL     = sel_q;
    assign bus.DIGIT_COUNT = cnt_q;
    assign bus.FULL        = full;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a digit-level model checked every cycle,
// directed scenarios with literal expectations, then randomized strobes and resets.
module tb_display_scan_ctrl;
    localparam int N        = 4;
    localparam int PRESCALE = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    bit   chk_en;

    display_scan_ctrl_if #(.N_DIGITS(N)) bus ();

    display_scan_ctrl #(.N_DIGITS(N), .PRESCALE(PRESCALE)) dut (
        .CLK  (clk),
        .RESET(rst),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: digit values, entry count, and clock edges since reset release.
    int         m_dig [N];
    int         m_cnt;
    int         m_edges;
    logic [6:0] exp_seg;
    logic [3:0] exp_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int idx);
        bit hi_zero = 1'b1;
        for (int j = idx; j < N; j++) if (m_dig[j] != 0) hi_zero = 1'b0;
        if (bus.BLANK_LZ && idx >= 1 && hi_zero) return 7'h00;
        return seg_tab[m_dig[idx]];
    endfunction

    // Outputs after edge e show digit floor((e-1)/PRESCALE) mod N from the buffer before that edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (m_dig[i]) m_dig[i] = 0;
            m_cnt   = 0;
            m_edges = 0;
            exp_seg = 7'h00;
            exp_sel = 4'h0;
        end else begin
            int idx;
            idx     = (m_edges / PRESCALE) % N;
            m_edges++;
            exp_sel = 4'(1 << idx);
            exp_seg = model_seg(idx);
            if (bus.CLEAR) begin
                foreach (m_dig[i]) m_dig[i] = 0;
                m_cnt = 0;
            end else if (bus.LOAD) begin
                foreach (m_dig[i]) m_dig[i] = int'(bus.LOAD_VALUE[4*i +: 4]);
                m_cnt = N;
            end else if (bus.DIGIT_VALID && m_cnt < N) begin
                for (int i = N - 1; i >= 1; i--) m_dig[i] = m_dig[i-1];
                m_dig[0] = int'(bus.DIGIT_IN);
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg",   32'(bus.SEG),         32'(exp_seg));
            check("model_sel",   32'(bus.DIG_SEL),     32'(exp_sel));
            check("model_count", 32'(bus.DIGIT_COUNT), 32'(m_cnt));
            check("model_full",  32'(bus.FULL),        32'(m_cnt == N));
        end
    end

    task automatic pulse(input logic clr, input logic ld, input logic dv,
                         input logic [3:0] d, input logic [15:0] lv);
        @(posedge clk); #1;
        bus.CLEAR       = clr;
        bus.LOAD        = ld;
        bus.DIGIT_VALID = dv;
        bus.DIGIT_IN    = d;
        bus.LOAD_VALUE  = lv;
        @(posedge clk); #1;
        bus.CLEAR       = 1'b0;
        bus.LOAD        = 1'b0;
        bus.DIGIT_VALID = 1'b0;
    endtask

    task automatic enter(input logic [3:0] d);
        pulse(1'b0, 1'b0, 1'b1, d, bus.LOAD_VALUE);
    endtask

    task automatic wait_slot(input logic [3:0] sel, output bit ok);
        ok = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.DIG_SEL == sel) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL wait_slot: DIG_SEL never reached %b, last %b", sel, bus.DIG_SEL);
        end
    endtask

    task automatic check_slot(input string name, input logic [3:0] sel, input logic [6:0] seg);
        bit ok;
        wait_slot(sel, ok);
        if (ok) check(name, 32'(bus.SEG), 32'(seg));
    endtask

    initial begin
        logic [3:0] seq [5];
        bit         ok;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n_vec  = 0;
        n_miss = 0;
        chk_en = 1'b0;
        rst    = 1'b0;
        bus.DIGIT_IN    = 4'h0;
        bus.DIGIT_VALID = 1'b0;
        bus.LOAD        = 1'b0;
        bus.LOAD_VALUE  = 16'h0;
        bus.CLEAR       = 1'b0;
        bus.BLANK_LZ    = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("reset_sel", 32'(bus.DIG_SEL), 32'h0);
        check("reset_seg", 32'(bus.SEG), 32'h0);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Scan sequence with a zero buffer and no blanking.
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            check("scan_sel", 32'(bus.DIG_SEL), 32'(seq[(e-1)/4]));
            check("scan_seg", 32'(bus.SEG), 32'h3F);
        end

        // Entry of 1,2,3 with leading-zero blanking.
        bus.BLANK_LZ = 1'b1;
        enter(4'h1); enter(4'h2); enter(4'h3);
        check("count_3", 32'(bus.DIGIT_COUNT), 32'd3);
        check_slot("e123_s3", 4'b1000, 7'h00);
        check_slot("e123_s2", 4'b0100, 7'h06);
        check_slot("e123_s1", 4'b0010, 7'h5B);
        check_slot("e123_s0", 4'b0001, 7'h4F);

        // Fill up; the fifth digit is ignored.
        enter(4'h4); enter(4'h5);
        check("full_1",  32'(bus.FULL), 32'd1);
        check("count_4", 32'(bus.DIGIT_COUNT), 32'd4);
        check_slot("e1234_s3", 4'b1000, 7'h06);
        check_slot("e1234_s0", 4'b0001, 7'h66);
        pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
        check("clear_count", 32'(bus.DIGIT_COUNT), 32'd0);
        check("clear_full",  32'(bus.FULL), 32'd0);

        // Strobe priority.
        pulse(1'b1, 1'b1, 1'b1, 4'h7, 16'hABCD);
        check("prio_clr_count", 32'(bus.DIGIT_COUNT), 32'd0);
        check_slot("prio_clr_s0", 4'b0001, 7'h3F);
        check_slot("prio_clr_s3", 4'b1000, 7'h00);
        pulse(1'b0, 1'b1, 1'b1, 4'h7, 16'hABCD);
        check("prio_ld_count", 32'(bus.DIGIT_COUNT), 32'd4);
        check_slot("abcd_s3", 4'b1000, 7'h77);
        check_slot("abcd_s2", 4'b0100, 7'h7C);
        check_slot("abcd_s1", 4'b0010, 7'h39);
        check_slot("abcd_s0", 4'b0001, 7'h5E);

        // Blanking of an all-zero buffer, then 0x0800.
        pulse(1'b1, 1'b0, 1'b0, 4'h0, 16'h0);
        check_slot("zero_s0", 4'b0001, 7'h3F);
        check_slot("zero_s1", 4'b0010, 7'h00);
        check_slot("zero_s2", 4'b0100, 7'h00);
        check_slot("zero_s3", 4'b1000, 7'h00);
        pulse(1'b0, 1'b1, 1'b0, 4'h0, 16'h0800);
        check_slot("0800_s3", 4'b1000, 7'h00);
        check_slot("0800_s2", 4'b0100, 7'h7F);
        check_slot("0800_s1", 4'b0010, 7'h3F);
        check_slot("0800_s0", 4'b0001, 7'h3F);

        // Asynchronous reset during the dwell of digit 2.
        bus.BLANK_LZ = 1'b0;
        pulse(1'b0, 1'b1, 1'b0, 4'h0, 16'h9876);
        wait_slot(4'b0100, ok);
        if (ok) check("pre_rst_seg", 32'(bus.SEG), 32'h7F);
        #2 rst = 1'b1;
        #1;
        check("rst_sel",   32'(bus.DIG_SEL), 32'h0);
        check("rst_seg",   32'(bus.SEG), 32'h0);
        check("rst_count", 32'(bus.DIGIT_COUNT), 32'd0);
        check("rst_full",  32'(bus.FULL), 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_sel", 32'(bus.DIG_SEL), 32'h1);
        check("post_rst_seg", 32'(bus.SEG), 32'h3F);

        // Randomized strobes and occasional resets, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.DIGIT_IN    = 4'($urandom);
            bus.LOAD_VALUE  = 16'($urandom);
            bus.DIGIT_VALID = ($urandom_range(0, 2) == 0);
            bus.LOAD        = ($urandom_range(0, 15) == 0);
            bus.CLEAR       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 63) == 0) bus.BLANK_LZ = ~bus.BLANK_LZ;
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                #3 rst = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.DIGIT_VALID = 1'b0;
        bus.LOAD        = 1'b0;
        bus.CLEAR       = 1'b0;
        repeat (4) @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
